// File: rtl/rpi_cap_pkg.sv
// Shared types and constants for the RPi 1-bit video capture path.
package rpi_cap_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VS,
        ACTIVE
    } state_t;

    localparam int unsigned PACK_W     = 8;
    localparam int unsigned FIFO_DEPTH = 2;

    // Left-justify a partial byte so the first pixel lands in the MSB.
    function automatic logic [PACK_W-1:0] pad_byte(input logic [PACK_W-1:0] sr,
                                                   input logic [3:0]        cnt);
        return sr << (PACK_W - 32'(cnt));
    endfunction

endpackage

// File: rtl/rpi_pixel_packer_if.sv
// Byte write port from the pixel packer towards the frame SRAM.
interface rpi_pixel_packer_if
    import rpi_cap_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) ();

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [PACK_W-1:0] wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rpi_pixel_packer.sv
// Samples RPi 1-bit video, packs 8 pixels per byte and queues frame-relative
// byte writes through a 2-entry holding FIFO.
module rpi_pixel_packer
    import rpi_cap_pkg::*;
#(
    parameter int unsigned       DIV_LOG2  = 3,
    parameter int unsigned       ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] MAX_ADDR  = 16'hFFFF,
    parameter bit                HS_ACTIVE = 1'b1,
    parameter bit                VS_ACTIVE = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rpi_h_sync,
    input  logic                      rpi_v_sync,
    input  logic                      rpi_color,
    input  logic                      capture_en,
    rpi_pixel_packer_if.master        wr,
    output logic                      frame_start,
    output logic                      frame_done,
    output logic                      overflow,
    output logic                      addr_full
);

    localparam logic [3:0] FULL_CNT  = 4'(PACK_W);
    localparam logic [1:0] FIFO_FULL = 2'(FIFO_DEPTH);

    logic hs_s, vs_s, px;

    sync_2ff u_sync_hs (.clk(clk), .rst_n(rst_n), .d(rpi_h_sync), .q(hs_s));
    sync_2ff u_sync_vs (.clk(clk), .rst_n(rst_n), .d(rpi_v_sync), .q(vs_s));
    sync_2ff u_sync_px (.clk(clk), .rst_n(rst_n), .d(rpi_color),  .q(px));

    logic hs_act, vs_act, hs_prev, vs_prev;
    logic hs_rise, vs_rise, vs_fall;

    assign hs_act  = (hs_s == HS_ACTIVE);
    assign vs_act  = (vs_s == VS_ACTIVE);
    assign hs_rise = hs_act & ~hs_prev;
    assign vs_rise = vs_act & ~vs_prev;
    assign vs_fall = ~vs_act & vs_prev;

    state_t state, state_next;
    logic   vs_seen, vs_seen_next;
    logic   start_evt, done_evt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            vs_seen <= 1'b0;
            hs_prev <= 1'b0;
            vs_prev <= 1'b0;
        end else begin
            state   <= state_next;
            vs_seen <= vs_seen_next;
            hs_prev <= hs_act;
            vs_prev <= vs_act;
        end
    end

    // Leaving ACTIVE on the vs edge pre-arms vs_seen so back-to-back frames chain.
    always_comb begin
        state_next   = state;
        vs_seen_next = vs_seen;
        start_evt    = 1'b0;
        done_evt     = 1'b0;
        if (!capture_en) begin
            state_next   = IDLE;
            vs_seen_next = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_next   = WAIT_VS;
                    vs_seen_next = 1'b0;
                end
                WAIT_VS: begin
                    if (vs_rise) begin
                        vs_seen_next = 1'b1;
                    end else if (vs_fall && vs_seen) begin
                        state_next   = ACTIVE;
                        vs_seen_next = 1'b0;
                        start_evt    = 1'b1;
                    end
                end
                ACTIVE: begin
                    if (vs_rise) begin
                        state_next   = WAIT_VS;
                        vs_seen_next = 1'b1;
                        done_evt     = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    logic [DIV_LOG2-1:0] div;
    logic [PACK_W-1:0]   shreg;
    logic [3:0]          bit_cnt;
    logic [ADDR_W:0]     addr;
    logic                keep, shift_en, byte_full, pad_push, push, addr_ok;
    logic [PACK_W-1:0]   push_data;

    assign keep      = (state == ACTIVE) && capture_en;
    assign shift_en  = keep && (div == '1) && !hs_act && !vs_act;
    assign byte_full = (bit_cnt == FULL_CNT);
    assign pad_push  = keep && (hs_rise || done_evt) && (bit_cnt != '0) && !byte_full;
    assign push      = byte_full || pad_push;
    assign push_data = byte_full ? shreg : pad_byte(shreg, bit_cnt);
    assign addr_ok   = (addr <= {1'b0, MAX_ADDR});

    logic              rd_ptr, wr_ptr;
    logic [1:0]        fcnt;
    logic              fifo_valid, fifo_full, pop, fifo_wr;
    logic [PACK_W-1:0] data_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];

    assign fifo_valid = (fcnt != '0);
    assign fifo_full  = (fcnt == FIFO_FULL);
    assign pop        = fifo_valid && wr.wr_ready;
    assign fifo_wr    = push && addr_ok && (!fifo_full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div     <= '0;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            div <= start_evt ? '0 : div + 1'b1;
            if (shift_en) begin
                shreg <= {shreg[PACK_W-2:0], px};
            end
            if (!keep || push) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    // A byte dropped for lack of FIFO space still consumes its address slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr        <= '0;
            overflow    <= 1'b0;
            addr_full   <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_start <= start_evt;
            frame_done  <= done_evt;
            if (start_evt) begin
                addr      <= '0;
                overflow  <= 1'b0;
                addr_full <= 1'b0;
            end else if (push) begin
                if (!addr_ok) begin
                    addr_full <= 1'b1;
                end else begin
                    addr <= addr + 1'b1;
                    if (fifo_full && !pop) begin
                        overflow <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_mem <= '{default: '0};
            addr_mem <= '{default: '0};
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            fcnt     <= '0;
        end else begin
            if (fifo_wr) begin
                data_mem[wr_ptr] <= push_data;
                addr_mem[wr_ptr] <= addr[ADDR_W-1:0];
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({fifo_wr, pop})
                2'b10:   fcnt <= fcnt + 1'b1;
                2'b01:   fcnt <= fcnt - 1'b1;
                default: fcnt <= fcnt;
            endcase
        end
    end

    assign wr.wr_valid = fifo_valid;
    assign wr.wr_data  = data_mem[rd_ptr];
    assign wr.wr_addr  = addr_mem[rd_ptr];

endmodule

// File: tb/tb_rpi_pixel_packer.sv
// Directed self-checking bench for rpi_pixel_packer (MAX_ADDR reduced to 3).
module tb_rpi_pixel_packer;

    logic clk = 1'b0;
    logic rst_n, rpi_h_sync, rpi_v_sync, rpi_color, capture_en;
    logic frame_start, frame_done, overflow, addr_full;

    int unsigned tests_run    = 0;
    int unsigned tests_failed = 0;
    int unsigned start_cnt    = 0;
    int unsigned done_cnt     = 0;
    logic [23:0] wq [$];

    rpi_pixel_packer_if #(.ADDR_W(16)) bus ();

    rpi_pixel_packer #(
        .DIV_LOG2 (3),
        .ADDR_W   (16),
        .MAX_ADDR (16'd3),
        .HS_ACTIVE(1'b1),
        .VS_ACTIVE(1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rpi_h_sync (rpi_h_sync),
        .rpi_v_sync (rpi_v_sync),
        .rpi_color  (rpi_color),
        .capture_en (capture_en),
        .wr         (bus.master),
        .frame_start(frame_start),
        .frame_done (frame_done),
        .overflow   (overflow),
        .addr_full  (addr_full)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.wr_valid && bus.wr_ready) wq.push_back({bus.wr_addr, bus.wr_data});
        if (frame_start) start_cnt <= start_cnt + 1;
        if (frame_done)  done_cnt  <= done_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_wr(input string tag, input logic [15:0] a, input logic [7:0] d);
        logic [23:0] got;
        got = '1;
        if (wq.size() != 0) got = wq.pop_front();
        chk(tag, 32'(got), 32'({a, d}));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One pixel slot: inputs change just after the strobe edge, sampled 8 clk later.
    task automatic pix(input logic b);
        rpi_color  = b;
        rpi_h_sync = 1'b0;
        cyc(8);
    endtask

    task automatic pix_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) pix(b[i]);
    endtask

    task automatic start_frame(input string tag);
        logic got;
        rpi_h_sync = 1'b0;
        rpi_color  = 1'b0;
        rpi_v_sync = 1'b1;
        cyc(4);
        rpi_v_sync = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (frame_start) got = 1'b1;
        end
        chk(tag, 32'(got), 32'd1);
    endtask

    task automatic end_frame();
        rpi_h_sync = 1'b0;
        rpi_v_sync = 1'b1;
        cyc(8);
    endtask

    logic [7:0]  b;
    logic [7:0]  t5 [6] = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h5A, 8'hA5};
    int unsigned s_done, s_start;

    initial begin
        rst_n = 1'b0; rpi_h_sync = 1'b0; rpi_v_sync = 1'b0; rpi_color = 1'b0;
        capture_en = 1'b0; bus.wr_ready = 1'b1;
        cyc(3);
        chk("reset_outs", 32'({bus.wr_valid, frame_start, frame_done, overflow, addr_full,
                               bus.wr_addr, bus.wr_data}), 32'd0);
        rst_n = 1'b1;
        cyc(2);

        // 1: async reset while a byte is pending
        capture_en = 1'b1;
        cyc(2);
        start_frame("t1_start");
        bus.wr_ready = 1'b0;
        pix_byte(8'hFF);
        cyc(2);
        chk("t1_pending", 32'({bus.wr_valid, bus.wr_addr, bus.wr_data}), 32'({1'b1, 16'd0, 8'hFF}));
        #2 rst_n = 1'b0;
        #1 chk("t1_async_outs", 32'({bus.wr_valid, frame_start, frame_done, overflow, addr_full,
                                     bus.wr_addr, bus.wr_data}), 32'd0);
        bus.wr_ready = 1'b1;
        wq.delete();
        s_start = start_cnt;
        cyc(2);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) pix(i[0]);
        chk("t1_no_writes", wq.size(), 0);
        chk("t1_no_start", start_cnt, s_start);

        // 2: 16-pixel line, 2-clk write latency, frame_done
        start_frame("t2_start");
        s_done = done_cnt;
        b = 8'hAA;
        for (int i = 7; i >= 0; i--) pix(b[i]);
        chk("t2_lat_before", 32'(bus.wr_valid), 32'd0);
        b = 8'hF0;
        rpi_color = b[7];
        cyc(1);
        chk("t2_lat_valid", 32'({bus.wr_valid, bus.wr_addr, bus.wr_data}), 32'({1'b1, 16'd0, 8'hAA}));
        cyc(7);
        for (int i = 6; i >= 0; i--) pix(b[i]);
        end_frame();
        chk("t2_done", done_cnt, s_done + 1);
        expect_wr("t2_w0", 16'd0, 8'hAA);
        expect_wr("t2_w1", 16'd1, 8'hF0);
        chk("t2_extra", wq.size(), 0);

        // 3: 11-pixel line closed by hs, next line realigned
        start_frame("t3_start");
        for (int i = 0; i < 11; i++) pix(1'b1);
        rpi_h_sync = 1'b1;
        cyc(8);
        pix_byte(8'h53);
        end_frame();
        expect_wr("t3_w0", 16'd0, 8'hFF);
        expect_wr("t3_w1", 16'd1, 8'hE0);
        expect_wr("t3_w2", 16'd2, 8'h53);
        chk("t3_extra", wq.size(), 0);

        // 4: backpressure fills the FIFO, third byte lost
        start_frame("t4_start");
        bus.wr_ready = 1'b0;
        pix_byte(8'h11);
        pix_byte(8'h22);
        chk("t4_hold0", 32'({bus.wr_valid, bus.wr_addr, bus.wr_data}), 32'({1'b1, 16'd0, 8'h11}));
        pix_byte(8'h33);
        b = 8'h44;
        rpi_color = b[7];
        cyc(2);
        chk("t4_hold1", 32'({bus.wr_valid, bus.wr_addr, bus.wr_data}), 32'({1'b1, 16'd0, 8'h11}));
        chk("t4_overflow", 32'(overflow), 32'd1);
        bus.wr_ready = 1'b1;
        cyc(6);
        for (int i = 6; i >= 0; i--) pix(b[i]);
        chk("t4_addr_full", 32'(addr_full), 32'd0);
        end_frame();
        expect_wr("t4_w0", 16'd0, 8'h11);
        expect_wr("t4_w1", 16'd1, 8'h22);
        expect_wr("t4_w2", 16'd3, 8'h44);
        chk("t4_extra", wq.size(), 0);

        // 5: address saturation at MAX_ADDR=3
        start_frame("t5_start");
        chk("t5_ovf_clr", 32'(overflow), 32'd0);
        for (int k = 0; k < 6; k++) pix_byte(t5[k]);
        chk("t5_addr_full", 32'(addr_full), 32'd1);
        end_frame();
        expect_wr("t5_w0", 16'd0, 8'h81);
        expect_wr("t5_w1", 16'd1, 8'h42);
        expect_wr("t5_w2", 16'd2, 8'h24);
        expect_wr("t5_w3", 16'd3, 8'h18);
        chk("t5_extra", wq.size(), 0);

        // 6: capture_en dropped mid-line
        start_frame("t6_start");
        chk("t6_afull_clr", 32'(addr_full), 32'd0);
        bus.wr_ready = 1'b0;
        pix_byte(8'h3C);
        for (int i = 0; i < 5; i++) pix(1'b1);
        capture_en = 1'b0;
        s_done  = done_cnt;
        s_start = start_cnt;
        cyc(4);
        chk("t6_pending", 32'({bus.wr_valid, bus.wr_addr, bus.wr_data}), 32'({1'b1, 16'd0, 8'h3C}));
        bus.wr_ready = 1'b1;
        cyc(2);
        rpi_v_sync = 1'b1;
        cyc(6);
        rpi_v_sync = 1'b0;
        cyc(10);
        chk("t6_no_done", done_cnt, s_done);
        chk("t6_no_start", start_cnt, s_start);
        expect_wr("t6_w0", 16'd0, 8'h3C);
        chk("t6_extra", wq.size(), 0);
        capture_en = 1'b1;
        cyc(2);
        start_frame("t6_restart");
        pix_byte(8'h0F);
        end_frame();
        expect_wr("t6_w1", 16'd0, 8'h0F);
        chk("t6_extra2", wq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
